// File: rtl/multi_cycle_control_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_cycle_control_if : datapath <-> multi-cycle control bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface multi_cycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             mem_ready;
  logic             PCEn;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             Link;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [5:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             Illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, Link,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, state,
           instr_count
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, Link,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, state,
           instr_count
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_cycle_control : Moore control FSM for a multi-cycle MIPS datapath
// Rev 1.0
// ----------------------------------------------------------------------------
module multi_cycle_control #(
  parameter int CNT_W = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  multi_cycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, link, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] alu_op;
  logic       funct_ok;

  always_comb begin
    funct_ok = 1'b0;
    case (bus.Funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
      default:                           funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    link          = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.Op)
          6'h00:        state_d = funct_ok ? EXEC : TRAP;
          6'h23, 6'h2B: state_d = MEMADR;
          6'h04:        state_d = BRANCH;
          6'h02, 6'h03: state_d = JUMP;
          6'h08:        state_d = ADDIEX;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.Op == 6'h2B) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = bus.Funct;
        state_d   = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        // jal: PC already holds PC+4, so the link value comes straight from PC
        if (bus.Op == 6'h03) begin
          reg_write = 1'b1;
          link      = 1'b1;
        end
        state_d = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Every path back into FETCH from another state completes an instruction.
  always_comb begin
    count_d = count_q;
    if (state_d == FETCH && state_q != FETCH) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign bus.PCEn        = ~reset & (pc_write | (pc_write_cond & bus.Zero));
  assign bus.IRWrite     = ~reset & ir_write;
  assign bus.RegWrite    = ~reset & reg_write;
  assign bus.MemWrite    = ~reset & mem_write;
  assign bus.MemRead     = ~reset & mem_read;
  assign bus.IorD        = iord;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegDst      = reg_dst;
  assign bus.Link        = link;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.PCSource    = pc_source;
  assign bus.Illegal     = (state_q == TRAP);
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore-style control FSM that sequences the MIPS datapath over several clocks per instruction instead of one.
- Sits beside the shared PC/IR/register-file/ALU/unified-memory datapath.
- Decodes Op/Funct from the instruction register and drives every mux select and write enable.
- Supports a memory ready handshake, flags illegal instructions, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Op  input  6  IR[31:26]
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- PCEn  output  1  PC load = PCWrite | (PCWriteCond & Zero)
- IorD  output  1  memory address: 0=PC, 1=ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- MemtoReg  output  1  reg write data: 0=ALUOut, 1=MDR
- RegDst  output  1  dest: 0=rt, 1=rd
- Link  output  1  dest=$31, data=PC (jal); overrides RegDst/MemtoReg
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  output  6  ALU control, funct encoding: add=6'h20, sub=6'h22, and=6'h24, or=6'h25, slt=6'h2A
- PCSource  output  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}
- Illegal  output  1  sticky illegal-instruction flag
- state  output  4  current state, debug
- instr_count  output  CNT_W  retired instructions

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12
- Reset:
  - state=FETCH, Illegal=0, instr_count=0.
  - While reset=1, PCEn, IRWrite, RegWrite, MemWrite and MemRead are forced 0.
  - Reset mid-instruction abandons it; no counter increment.
- Unlisted outputs are 0 in each state; ALUOp defaults to add.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - If mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE.
  - Otherwise IRWrite=0 and PCEn=0, and the FSM stays in FETCH. This gating is the only Mealy path besides Zero.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by Op:
  - 6'h00 → EXEC if Funct ∈ {20,22,24,25,2A}, else TRAP
  - 6'h23 (lw) or 6'h2B (sw) → MEMADR
  - 6'h04 (beq) → BRANCH
  - 6'h02 (j) or 6'h03 (jal) → JUMP
  - 6'h08 (addi) → ADDIEX
  - any other Op → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready=1, then go to FETCH. MemWrite stays asserted while waiting.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=Funct; then RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01; then FETCH. PCEn=Zero.
- JUMP: PCWrite=1, PCSource=10. For jal (Op=03) also RegWrite=1 and Link=1 (writes PC+4, already in PC). Then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add; then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
- TRAP:
  - Illegal=1; all enables 0.
  - Stays in TRAP until reset.
  - TRAP entry does not count as a retire.
- instr_count:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR (on mem_ready), RWB, BRANCH, JUMP or ADDIWB.
  - Wraps modulo 2^CNT_W.
- Latencies including FETCH/DECODE, with zero wait:
  - R-type 4, lw 5, sw 4, beq 3, j/jal 3, addi 4 cycles.
  - Each wait cycle adds 1 in FETCH/MEMRD/MEMWR.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Test Plan:
- reset=1 for 2 cycles, mem_ready=1 → state=0, all enables 0, instr_count=0; on release, IRWrite=PCEn=1 in the first cycle.
- add (Op=00, Funct=20), mem_ready=1 → states 0,1,6,7,0 over 4 cycles; RegWrite=1, RegDst=1 only in state 7; instr_count 0→1.
- lw (Op=23) with mem_ready=0 for 3 cycles in MEMRD → stays in state 3 with MemRead=1, IorD=1 for 4 cycles total; MEMWB writes with MemtoReg=1; 8 total cycles.
- beq (Op=04): Zero=1 → PCEn=1, PCSource=01 in state 8. Zero=0 → PCEn=0. In both cases next state=0 and count +1.
- jal (Op=03) → state 9 with PCWrite=1, PCSource=10, RegWrite=1, Link=1; then FETCH.
- Op=3F, then Op=00/Funct=3F after reset → state 12, Illegal=1, count unchanged; stays in state 12 for 10 cycles; reset clears to FETCH with Illegal=0.
